// File: rtl/pulse_decoder_defs.sv
// Shared definitions for the pulse train decoder: FSM state encoding and default sizing.
package pulse_decoder_defs;

    localparam int unsigned DEF_CW      = 8;
    localparam int unsigned DEF_BW      = 4;
    localparam int unsigned DEF_MIN_W   = 2;
    localparam int unsigned DEF_MAX_W   = 16;
    localparam int unsigned DEF_GAP_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HIGH     = 2'd1,
        ST_LOW      = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer with rise/fall detection for the pulse train input.
// Optional glitch filter enabled by PULSE_GLITCH_FILTER_EN.
module pulse_sync (
    input  logic clock,
    input  logic reset,
    input  logic i_signal,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_s_d;
    logic w_s;

`ifdef PULSE_GLITCH_FILTER_EN
    logic r_sync3;
    logic r_hold;

    // Level only moves once the synchronized input has been stable for two samples.
    assign w_s = (r_sync2 == r_sync3) ? r_sync2 : r_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync3 <= 1'b0;
            r_hold  <= 1'b0;
        end else begin
            r_sync3 <= r_sync2;
            r_hold  <= w_s;
        end
    end
`else
    assign w_s = r_sync2;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_s_d   <= 1'b0;
        end else begin
            r_sync1 <= i_signal;
            r_sync2 <= r_sync1;
            r_s_d   <= w_s;
        end
    end

    assign o_level = w_s;
    assign o_rise  = w_s & ~r_s_d;
    assign o_fall  = ~w_s & r_s_d;

endmodule

// File: rtl/pulse_train_decoder.sv
// Measures high/low intervals of an asynchronous pulse train, validates widths and reports bursts.
// Build with PULSE_GLITCH_FILTER_EN to discard single-cycle input levels.
module pulse_train_decoder
    import pulse_decoder_defs::*;
#(
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned MIN_W   = DEF_MIN_W,
    parameter int unsigned MAX_W   = DEF_MAX_W,
    parameter int unsigned GAP_MAX = DEF_GAP_MAX,
    parameter int unsigned BW      = DEF_BW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          signal,
    output logic          width_valid,
    output logic [CW-1:0] high_width,
    output logic [CW-1:0] low_width,
    output logic          burst_done,
    output logic [BW-1:0] burst_count,
    output logic          error
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_lcnt;
    logic [CW-1:0] r_last_low;
    logic [BW-1:0] r_pcount;

    logic          w_level;
    logic          w_rise;
    logic          w_fall;
    logic          w_high_ok;
    logic          w_low_ok;
    logic          w_hcnt_ovf;
    logic          w_gap;
    logic [CW-1:0] w_lcnt_inc;
    logic [BW-1:0] w_pcount_inc;

    logic          w_wv;
    logic          w_err;
    logic          w_bd;
    logic [CW-1:0] w_hcnt_nxt;
    logic [CW-1:0] w_lcnt_nxt;
    logic [CW-1:0] w_last_low_nxt;
    logic [BW-1:0] w_pcount_nxt;

    pulse_sync u_sync (
        .clock    (clock),
        .reset    (reset),
        .i_signal (signal),
        .o_level  (w_level),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    assign w_high_ok    = (r_hcnt >= CW'(MIN_W));
    assign w_low_ok     = (r_lcnt >= CW'(MIN_W));
    assign w_hcnt_ovf   = (r_hcnt >= CW'(MAX_W));
    assign w_gap        = (r_lcnt == CW'(GAP_MAX));
    assign w_lcnt_inc   = (r_lcnt == '1) ? r_lcnt : r_lcnt + CW'(1);
    assign w_pcount_inc = (r_pcount == '1) ? r_pcount : r_pcount + BW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (w_fall)                    w_state_nxt = w_high_ok ? ST_LOW : ST_IDLE;
                else if (w_level && w_hcnt_ovf) w_state_nxt = ST_WAIT_LOW;
            end
            ST_LOW: begin
                // Gap terminal count wins over a coincident rise.
                if (w_gap)       w_state_nxt = w_rise ? ST_HIGH : ST_IDLE;
                else if (w_rise) w_state_nxt = w_low_ok ? ST_HIGH : ST_IDLE;
            end
            ST_WAIT_LOW: begin
                if (!w_level) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_wv           = 1'b0;
        w_err          = 1'b0;
        w_bd           = 1'b0;
        w_hcnt_nxt     = r_hcnt;
        w_lcnt_nxt     = r_lcnt;
        w_last_low_nxt = r_last_low;
        w_pcount_nxt   = r_pcount;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_hcnt_nxt     = CW'(1);
                    w_last_low_nxt = '0;
                    w_pcount_nxt   = '0;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    if (w_high_ok) begin
                        w_wv         = 1'b1;
                        w_pcount_nxt = w_pcount_inc;
                        w_lcnt_nxt   = CW'(1);
                    end else begin
                        w_err        = 1'b1;
                        w_pcount_nxt = '0;
                    end
                end else if (w_level && w_hcnt_ovf) begin
                    w_err        = 1'b1;
                    w_pcount_nxt = '0;
                end else begin
                    w_hcnt_nxt = r_hcnt + CW'(1);
                end
            end
            ST_LOW: begin
                if (w_gap) begin
                    w_bd         = 1'b1;
                    w_pcount_nxt = '0;
                    if (w_rise) begin
                        w_hcnt_nxt     = CW'(1);
                        w_last_low_nxt = '0;
                    end
                end else if (w_rise) begin
                    if (w_low_ok) begin
                        w_last_low_nxt = r_lcnt;
                        w_hcnt_nxt     = CW'(1);
                    end else begin
                        w_err        = 1'b1;
                        w_pcount_nxt = '0;
                    end
                end else begin
                    w_lcnt_nxt = w_lcnt_inc;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hcnt      <= '0;
            r_lcnt      <= '0;
            r_last_low  <= '0;
            r_pcount    <= '0;
            width_valid <= 1'b0;
            high_width  <= '0;
            low_width   <= '0;
            burst_done  <= 1'b0;
            burst_count <= '0;
            error       <= 1'b0;
        end else begin
            r_hcnt      <= w_hcnt_nxt;
            r_lcnt      <= w_lcnt_nxt;
            r_last_low  <= w_last_low_nxt;
            r_pcount    <= w_pcount_nxt;
            width_valid <= w_wv;
            burst_done  <= w_bd;
            error       <= w_err;
            if (w_wv) begin
                high_width <= r_hcnt;
                low_width  <= r_last_low;
            end
            if (w_bd) begin
                burst_count <= r_pcount;
            end
        end
    end

endmodule
